// File: rtl/vblank_update_scheduler_if.sv
// Bundle of sync-generator coordinates, client handshake and scheduler status.
// master: the scheduler; slave: sync generator plus update clients.
interface vblank_update_scheduler_if #(
  parameter int N_CLIENTS = 4
);
  logic [10:0]          pixelX;
  logic [10:0]          pixelY;
  logic [N_CLIENTS-1:0] req;
  logic [N_CLIENTS-1:0] done;
  logic [N_CLIENTS-1:0] gnt;
  logic                 frame_tick;
  logic                 busy;
  logic                 window_open;
  logic                 overrun;
  logic [15:0]          frame_cnt;
  logic                 wd_fire;

  modport master (
    input  pixelX, pixelY, req, done,
    output gnt, frame_tick, busy, window_open, overrun, frame_cnt, wd_fire
  );

  modport slave (
    output pixelX, pixelY, req, done,
    input  gnt, frame_tick, busy, window_open, overrun, frame_cnt, wd_fire
  );
endinterface

// File: rtl/vblank_update_scheduler.sv
// Round-robin, once-per-frame grant of the vertical-blanking window to N update clients.
// Optional grant watchdog compiled in with `define UPD_WATCHDOG_EN.
//
// state | meaning
// IDLE  | no grant; picks next eligible client from rr_ptr upward
// BUSY  | one client holds gnt until its done (or watchdog expiry)
module vblank_update_scheduler #(
  parameter int          N_CLIENTS  = 4,
  parameter logic [10:0] V_ACTIVE   = 11'd480,
  parameter logic [10:0] DEADLINE_Y = 11'd2040,
  parameter logic [15:0] WD_CYCLES  = 16'd4000
) (
  input logic                         vga_clk,
  input logic                         reset,
  vblank_update_scheduler_if.master   bus
);
  localparam int IW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [N_CLIENTS-1:0] gnt_q, gnt_d;
  logic [N_CLIENTS-1:0] served_q, served_d;
  logic [IW-1:0]        sel_q, sel_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                 frame_tick_q, frame_tick_d;
  logic                 busy_q, busy_d;
  logic                 window_open_q, window_open_d;
  logic                 overrun_q, overrun_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;

  logic                 sof, ddl;
  logic [N_CLIENTS-1:0] eligible;
  logic                 found;
  logic [IW-1:0]        pick;
  logic                 done_hit;
  logic                 wd_hit;

  assign sof      = (bus.pixelY == V_ACTIVE)   && (bus.pixelX == 11'd0);
  assign ddl      = (bus.pixelY == DEADLINE_Y) && (bus.pixelX == 11'd0);
  assign eligible = bus.req & ~served_q & {N_CLIENTS{window_open_q}};
  assign done_hit = (state_q == BUSY) && bus.done[sel_q];

  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      idx = (int'(rr_ptr_q) + i) % N_CLIENTS;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

`ifdef UPD_WATCHDOG_EN
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        wd_fire_q;

  assign wd_hit = (state_q == BUSY) && !bus.done[sel_q] && (wd_cnt_q == WD_CYCLES - 16'd1);

  // Held at zero while idle, so the count restarts on every new grant.
  always_comb begin
    wd_cnt_d = '0;
    if (state_q == BUSY) wd_cnt_d = wd_cnt_q + 16'd1;
  end

  always_ff @(negedge vga_clk) begin
    if (reset) begin
      wd_cnt_q  <= '0;
      wd_fire_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      wd_fire_q <= wd_hit;
    end
  end

  assign bus.wd_fire = wd_fire_q;
`else
  logic unused_wd_cycles;
  assign unused_wd_cycles = ^WD_CYCLES;
  assign wd_hit           = 1'b0;
  assign bus.wd_fire      = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    served_d      = served_q;
    sel_d         = sel_q;
    rr_ptr_d      = rr_ptr_q;
    busy_d        = busy_q;
    window_open_d = window_open_q;
    overrun_d     = overrun_q;
    frame_cnt_d   = frame_cnt_q;
    frame_tick_d  = sof;

    if (sof) begin
      frame_cnt_d   = frame_cnt_q + 16'd1;
      window_open_d = 1'b1;
      served_d      = '0;
      overrun_d     = 1'b0;
    end

    if (ddl) begin
      window_open_d = 1'b0;
      if ((state_q == BUSY) || (|(bus.req & ~served_q))) overrun_d = 1'b1;
    end

    if (state_q == IDLE) begin
      if (found) begin
        gnt_d       = '0;
        gnt_d[pick] = 1'b1;
        sel_d       = pick;
        busy_d      = 1'b1;
        state_d     = BUSY;
      end
    end else begin
      // served is cleared by sof above first, so a coincident done still marks this frame.
      if (done_hit || wd_hit) begin
        gnt_d           = '0;
        busy_d          = 1'b0;
        served_d[sel_q] = 1'b1;
        rr_ptr_d        = (sel_q == IW'(N_CLIENTS - 1)) ? '0 : sel_q + IW'(1);
        state_d         = IDLE;
      end
    end

    if (wd_hit) overrun_d = 1'b1;
  end

  always_ff @(negedge vga_clk) begin
    if (reset) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      served_q      <= '0;
      sel_q         <= '0;
      rr_ptr_q      <= '0;
      frame_tick_q  <= 1'b0;
      busy_q        <= 1'b0;
      window_open_q <= 1'b0;
      overrun_q     <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      served_q      <= served_d;
      sel_q         <= sel_d;
      rr_ptr_q      <= rr_ptr_d;
      frame_tick_q  <= frame_tick_d;
      busy_q        <= busy_d;
      window_open_q <= window_open_d;
      overrun_q     <= overrun_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.frame_tick  = frame_tick_q;
  assign bus.busy        = busy_q;
  assign bus.window_open = window_open_q;
  assign bus.overrun     = overrun_q;
  assign bus.frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_vblank_update_scheduler.sv
// Self-checking bench for vblank_update_scheduler: directed scenarios plus a
// randomized run against a frame-level reference model.
module tb_vblank_update_scheduler;
  localparam int          N  = 4;
  localparam logic [10:0] VA = 11'd480;
  localparam logic [10:0] DL = 11'd2040;
  localparam int          WD = 16;

  logic vga_clk = 1'b0;
  logic reset   = 1'b1;

  vblank_update_scheduler_if #(.N_CLIENTS(N)) bus ();

  vblank_update_scheduler #(
    .N_CLIENTS (N),
    .V_ACTIVE  (VA),
    .DEADLINE_Y(DL),
    .WD_CYCLES (16'(WD))
  ) dut (
    .vga_clk(vga_clk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 vga_clk = ~vga_clk;

  int total = 0;
  int bad   = 0;

  // Reference model: granted client index (-1 = none) and per-frame bookkeeping.
  int          m_gnt;
  logic [N-1:0] m_served;
  int          m_ptr;
  bit          m_win, m_ovr, m_tick, m_wd;
  logic [15:0] m_cnt;
  int          m_wdc;

  task automatic model_step(input bit rst, input bit sof, input bit ddl,
                            input logic [N-1:0] r, input logic [N-1:0] d);
    int n_gnt, n_ptr, n_wdc;
    logic [N-1:0] n_served;
    bit n_win, n_ovr, n_wd;
    logic [15:0] n_cnt;
    if (rst) begin
      m_gnt = -1; m_served = '0; m_ptr = 0; m_win = 0; m_ovr = 0;
      m_tick = 0; m_wd = 0; m_cnt = '0; m_wdc = 0;
    end else begin
      n_gnt = m_gnt; n_ptr = m_ptr; n_wdc = m_wdc; n_served = m_served;
      n_win = m_win; n_ovr = m_ovr; n_wd = 0; n_cnt = m_cnt;
      if (sof) begin
        n_cnt = m_cnt + 16'd1; n_win = 1; n_served = '0; n_ovr = 0;
      end
      if (ddl) begin
        n_win = 0;
        if (m_gnt >= 0 || (r & ~m_served) != '0) n_ovr = 1;
      end
      if (m_gnt < 0) begin
        if (m_win) begin
          for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (r[c] && !m_served[c]) begin
              n_gnt = c; n_wdc = 0;
              break;
            end
          end
        end
      end else if (d[m_gnt]) begin
        n_served[m_gnt] = 1'b1; n_ptr = (m_gnt + 1) % N; n_gnt = -1;
      end
`ifdef UPD_WATCHDOG_EN
      else if (m_wdc == WD - 1) begin
        n_served[m_gnt] = 1'b1; n_ptr = (m_gnt + 1) % N; n_gnt = -1;
        n_wd = 1; n_ovr = 1;
      end else begin
        n_wdc = m_wdc + 1;
      end
`endif
      m_gnt = n_gnt; m_ptr = n_ptr; m_wdc = n_wdc; m_served = n_served;
      m_win = n_win; m_ovr = n_ovr; m_wd = n_wd; m_cnt = n_cnt; m_tick = sof;
    end
  endtask

  // One vga_clk cycle: drive coordinates, let the DUT and model take the negedge,
  // return just after the following posedge with done cleared.
  task automatic step(input bit ev_sof, input bit ev_ddl);
    int x, y;
    if (ev_sof) begin
      bus.pixelX = 11'd0; bus.pixelY = VA;
    end else if (ev_ddl) begin
      bus.pixelX = 11'd0; bus.pixelY = DL;
    end else begin
      x = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 2047);
      y = $urandom_range(0, 2047);
      if (x == 0 && (y == int'(VA) || y == int'(DL))) y = y + 1;
      bus.pixelX = 11'(x); bus.pixelY = 11'(y);
    end
    @(negedge vga_clk);
    model_step(reset, ev_sof, ev_ddl, bus.req, bus.done);
    @(posedge vga_clk);
    bus.done = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.req = '0; bus.done = '0;
    step(0, 0); step(0, 0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.req = 4'($urandom); bus.done = '0;
    step(0, 0); step(1, 0); step(0, 0);
    total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b want=0000", bus.gnt); end
    total++; if (bus.frame_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b want=0", bus.frame_tick); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.window_open !== 1'b0) begin bad++; $display("FAIL reset_win got=%b want=0", bus.window_open); end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b want=0", bus.overrun); end
    total++; if (bus.frame_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", bus.frame_cnt); end
    total++; if (bus.wd_fire !== 1'b0) begin bad++; $display("FAIL reset_wd got=%b want=0", bus.wd_fire); end
    reset = 1'b0; bus.req = '0;
  endtask

  task automatic test_sof();
    do_reset();
    step(1, 0);
    total++; if (bus.frame_tick !== 1'b1) begin bad++; $display("FAIL sof_tick got=%b want=1", bus.frame_tick); end
    total++; if (bus.frame_cnt !== 16'd1) begin bad++; $display("FAIL sof_cnt got=%0d want=1", bus.frame_cnt); end
    total++; if (bus.window_open !== 1'b1) begin bad++; $display("FAIL sof_win got=%b want=1", bus.window_open); end
    total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL sof_gnt got=%b want=0000", bus.gnt); end
    step(0, 0);
    total++; if (bus.frame_tick !== 1'b0) begin bad++; $display("FAIL sof_tick_once got=%b want=0", bus.frame_tick); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp;
    do_reset();
    bus.req = 4'b1111;
    for (int f = 0; f < 2; f++) begin
      step(1, 0);
      for (int k = 0; k < N; k++) begin
        int w;
        w = 0;
        while (bus.gnt == '0 && w < 10) begin step(0, 0); w++; end
        exp = '0; exp[k] = 1'b1;
        total++; if (bus.gnt !== exp) begin bad++; $display("FAIL rr_order frame=%0d k=%0d got=%b want=%b", f, k, bus.gnt, exp); end
        step(0, 0); step(0, 0);
        bus.done = bus.gnt;
        step(0, 0);
        total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL rr_release got=%b want=0000", bus.gnt); end
      end
      repeat (4) step(0, 0);
      total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL rr_once_per_frame got=%b want=0000", bus.gnt); end
    end
  endtask

  task automatic test_late_request();
    do_reset();
    bus.req = 4'b0100;
    step(1, 0); step(0, 0);
    total++; if (bus.gnt !== 4'b0100) begin bad++; $display("FAIL late_first got=%b want=0100", bus.gnt); end
    bus.req = 4'b0101;
    step(0, 0);
    total++; if (bus.gnt !== 4'b0100) begin bad++; $display("FAIL late_hold got=%b want=0100", bus.gnt); end
    bus.done = 4'b0100;
    step(0, 0);
    total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL late_idle got=%b want=0000", bus.gnt); end
    step(0, 0);
    total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL late_next got=%b want=0001", bus.gnt); end
    bus.done = 4'b0001;
    step(0, 0); step(0, 0); step(0, 0); step(0, 0);
    total++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin bad++; $display("FAIL late_no_regrant gnt=%b busy=%b want gnt=0000 busy=0", bus.gnt, bus.busy); end
  endtask

  task automatic test_ignored_done();
    do_reset();
    bus.req = 4'b0010;
    step(1, 0); step(0, 0);
    bus.req = 4'b0011; bus.done = 4'b0001;
    step(0, 0);
    total++; if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL foreign_done got=%b want=0010", bus.gnt); end
    bus.done = 4'b0010;
    step(0, 0); step(0, 0);
    total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL served0_clear got=%b want=0001", bus.gnt); end
  endtask

  task automatic test_deadline();
    do_reset();
    bus.req = 4'b0010;
    step(1, 0); step(0, 0); step(0, 0); step(0, 0);
    step(0, 1);
    total++; if (bus.window_open !== 1'b0) begin bad++; $display("FAIL ddl_win got=%b want=0", bus.window_open); end
    total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL ddl_ovr got=%b want=1", bus.overrun); end
    total++; if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL ddl_hold got=%b want=0010", bus.gnt); end
    bus.done = 4'b0010;
    step(0, 0);
    bus.req = 4'b1111;
    step(0, 0); step(0, 0); step(0, 0);
    total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL ddl_no_grant got=%b want=0000", bus.gnt); end
    step(1, 0);
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL ddl_ovr_clear got=%b want=0", bus.overrun); end
    step(0, 0);
    total++; if (bus.gnt !== 4'b0100) begin bad++; $display("FAIL ddl_resume got=%b want=0100", bus.gnt); end
  endtask

  task automatic test_sof_done_coincident();
    do_reset();
    bus.req = 4'b0001;
    step(1, 0); step(0, 0);
    step(0, 1);
    total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL coinc_ovr got=%b want=1", bus.overrun); end
    bus.done = 4'b0001;
    step(1, 0);
    total++; if (bus.gnt !== 4'b0000 || bus.frame_tick !== 1'b1 || bus.overrun !== 1'b0) begin bad++; $display("FAIL coinc_apply gnt=%b tick=%b ovr=%b want 0000 1 0", bus.gnt, bus.frame_tick, bus.overrun); end
    step(0, 0); step(0, 0); step(0, 0);
    total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL coinc_served got=%b want=0000", bus.gnt); end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    bus.req = 4'b1000;
    step(1, 0); step(0, 0);
    reset = 1'b1;
    step(0, 0);
    total++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin bad++; $display("FAIL midreset gnt=%b busy=%b want 0000 0", bus.gnt, bus.busy); end
    reset = 1'b0;
    step(0, 0); step(0, 0);
    total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL midreset_after got=%b want=0000", bus.gnt); end
  endtask

`ifdef UPD_WATCHDOG_EN
  task automatic test_watchdog();
    int held, fires;
    do_reset();
    bus.req = 4'b0011;
    step(1, 0); step(0, 0);
    held = (bus.gnt == 4'b0001) ? 1 : 0; fires = 0;
    for (int i = 0; i < 40 && bus.gnt == 4'b0001; i++) begin
      step(0, 0);
      if (bus.gnt == 4'b0001) held++;
      if (bus.wd_fire) fires++;
    end
    total++; if (held != 16) begin bad++; $display("FAIL wd_hold got=%0d want=16", held); end
    total++; if (fires != 1) begin bad++; $display("FAIL wd_fire_count got=%0d want=1", fires); end
    total++; if (bus.overrun !== 1'b1 || bus.gnt !== 4'b0000) begin bad++; $display("FAIL wd_drop ovr=%b gnt=%b want 1 0000", bus.overrun, bus.gnt); end
    step(0, 0);
    total++; if (bus.gnt !== 4'b0010 || bus.wd_fire !== 1'b0) begin bad++; $display("FAIL wd_next gnt=%b wd=%b want 0010 0", bus.gnt, bus.wd_fire); end
  endtask
`else
  task automatic test_watchdog();
    int fires;
    do_reset();
    bus.req = 4'b0011;
    step(1, 0); step(0, 0);
    fires = 0;
    repeat (60) begin step(0, 0); if (bus.wd_fire !== 1'b0) fires++; end
    total++; if (fires != 0) begin bad++; $display("FAIL nowd_fire got=%0d want=0", fires); end
    total++; if (bus.gnt !== 4'b0001 || bus.busy !== 1'b1) begin bad++; $display("FAIL nowd_hold gnt=%b busy=%b want 0001 1", bus.gnt, bus.busy); end
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] exp_gnt;
    logic [22:0] got, exp;
    int errs;
    do_reset();
    errs = 0;
    for (int f = 0; f < 20; f++) begin
      int len_a, len_b;
      len_a = $urandom_range(15, 60);
      len_b = $urandom_range(3, 20);
      for (int c = 0; c < len_a + len_b + 2; c++) begin
        if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom);
        bus.done = 4'($urandom) & 4'($urandom) & 4'($urandom);
        step(c == 0, c == len_a + 1);
        exp_gnt = '0;
        if (m_gnt >= 0) exp_gnt[m_gnt] = 1'b1;
        got = {bus.gnt, bus.busy, bus.frame_tick, bus.window_open, bus.overrun, bus.wd_fire, bus.frame_cnt};
        exp = {exp_gnt, (m_gnt >= 0), m_tick, m_win, m_ovr, m_wd, m_cnt};
        total++;
        if (got !== exp) begin
          bad++; errs++;
          if (errs < 10) $display("FAIL random f=%0d c=%0d got=%h want=%h", f, c, got, exp);
        end
      end
    end
  endtask

  initial begin
    bus.pixelX = 11'd1; bus.pixelY = 11'd0; bus.req = '0; bus.done = '0;
    @(posedge vga_clk);
    test_reset();
    test_sof();
    test_round_robin();
    test_late_request();
    test_ignored_done();
    test_deadline();
    test_sof_done_coincident();
    test_reset_mid_grant();
    test_watchdog();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vblank_update_scheduler.md
Name: vblank_update_scheduler

Overview:
- Shares the vertical-blanking window between N game-object update clients (invaders, player, shots, shields).
- Watches the 11-bit pixelX/pixelY coordinates produced by the video sync generator on the pixel clock.
- Issues a one-cycle frame tick at the start of vertical blanking, then grants clients exclusive access one at a time, round-robin, at most once per frame.
- Closes the window at a programmable deadline line and flags overruns.

Parameters:
- N_CLIENTS, 4, number of requesters, legal 2..8.
- V_ACTIVE, 11'd480, pixelY value of the first non-visible line; the window opens here.
- DEADLINE_Y, 11'd2040, pixelY value (wrapped back-porch line) at which the window closes.
- WD_CYCLES, 16'd4000, watchdog limit in vga_clk cycles (used only with the optional feature).

Ports:
- vga_clk  in  1  pixel clock; all logic on negedge vga_clk, matching the sync generator.
- reset  in  1  synchronous, active-high reset.
- pixelX  in  11  current pixel column from the sync generator.
- pixelY  in  11  current pixel row from the sync generator; wraps modulo 2048.
- req  in  N_CLIENTS  per-client level request.
- done  in  N_CLIENTS  per-client one-cycle completion pulse.
- gnt  out  N_CLIENTS  one-hot grant, or all zero.
- frame_tick  out  1  one-cycle pulse per frame.
- busy  out  1  high while any grant is active.
- window_open  out  1  high between window open and deadline.
- overrun  out  1  sticky deadline-miss flag.
- frame_cnt  out  16  frame counter, wraps.
- wd_fire  out  1  watchdog pulse; tied 0 when the optional feature is compiled out.

Behaviour:
- Clocking and reset:
  - Single clock vga_clk, negedge; reset is synchronous and active-high.
  - Reset values: gnt=0, frame_tick=0, busy=0, window_open=0, overrun=0, frame_cnt=0, wd_fire=0.
  - Internal reset values: served mask=0, rr_ptr=0, state=IDLE.
  - Reset mid-grant drops gnt on the next edge; there is no handshake completion.
- Event decode (combinational):
  - sof = (pixelY==V_ACTIVE && pixelX==0).
  - ddl = (pixelY==DEADLINE_Y && pixelX==0).
  - Each fires for exactly one cycle per frame.
- On sof (registered, visible the next cycle):
  - frame_tick=1 for one cycle.
  - frame_cnt+1, wrapping 16'hFFFF->0.
  - window_open=1; served cleared; overrun cleared.
- On ddl:
  - window_open=0.
  - overrun=1 if state==BUSY, or if any (req & ~served) is nonzero.
- Eligibility: eligible = req & ~served, qualified by window_open.
- State IDLE:
  - If eligible is nonzero, select the first set bit searching from rr_ptr upward with wrap.
  - gnt[sel]=1 from the next cycle; busy=1; move to BUSY.
- State BUSY:
  - gnt is held, regardless of req, until done[sel]=1. done bits of non-granted clients are ignored.
  - On done[sel], the next cycle sets gnt=0, busy=0, served[sel]=1, rr_ptr=(sel+1) mod N_CLIENTS, and returns to IDLE.
  - At least one idle cycle separates consecutive grants. Grant latency is 1 cycle from eligibility.
- No preemption:
  - ddl during BUSY leaves gnt held until done; no new grants until the next sof.
  - sof during BUSY (previous-frame overrun) keeps the grant. served is cleared first; a done in the same cycle then sets served[sel].
- Coincident events: sof and done in the same cycle are both applied. done on a cycle where window_open falls still completes normally.
- Requests: a req that deasserts while not granted is simply not selected. Request timing never produces a multi-hot gnt.

Optional Feature:
- Macro: UPD_WATCHDOG_EN.
- Defined:
  - A 16-bit counter runs while BUSY and clears on entering BUSY.
  - Reaching WD_CYCLES-1 without done forces gnt=0 and served[sel]=1, advances rr_ptr as for a done, pulses wd_fire for 1 cycle, and sets overrun.
- Undefined:
  - No counter logic is built and wd_fire is constant 0.
  - A missing done holds gnt indefinitely; recovery is by reset only.

Test Plan:
- Reset release, then pixelY=480 and pixelX=0 for one cycle -> frame_tick=1 on the next cycle only, frame_cnt=1, window_open=1, gnt=0.
- req=4'b1111 after sof, each client returns done 3 cycles after its grant -> gnt sequence 0001, 0010, 0100, 1000, each a single grant; a second frame with req stuck high gives the same order with rr_ptr=0 again.
- req=4'b0100 alone, then req=4'b0001 raised while client 2 is BUSY -> client 0 is granted only after client 2's done plus 1 idle cycle; client 2 is not re-granted that frame.
- Client 1 granted and no done before pixelY=2040, pixelX=0 -> window_open=0, overrun=1, gnt stays 0010; after done, no further grants. Next sof clears overrun.
- done=4'b0001 pulsed while gnt=0010 -> ignored; gnt is unchanged and served[0] stays 0.
- With UPD_WATCHDOG_EN and WD_CYCLES=16, a granted client that never asserts done -> gnt drops after 16 cycles, wd_fire pulses once, overrun=1, and the next eligible client is granted one idle cycle later.
